lock_controller: RTL

- Top-level sequencer for the digital lock's pin-code tester.
- Owns the stored pin code and enables/clears the tester.
- Consumes per-attempt results; counts failures and enforces a lockout period.
- Times the unlocked window and supports reprogramming the code while unlocked.

---
 rtl/lock_pkg.sv | 35 +++
 rtl/lock_controller_if.sv | 24 ++
 rtl/lock_timer.sv | 33 +++
 rtl/lock_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared types and width helpers for the lock controller slice.
//   lock_state_e - sequencer states (PROGRAM_CONFIRM only reachable when
//                  LOCK_PROGRAM_CONFIRM_EN is defined)
//   lock_outs_t  - bundle of the single-bit registered status outputs
//   timer_width  - bits needed by the shared lockout/unlock down-counter
//   fail_width   - bits needed by the saturating failure counter
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED          = 3'd0,
    UNLOCKED        = 3'd1,
    PROGRAM         = 3'd2,
    LOCKOUT         = 3'd3,
    PROGRAM_CONFIRM = 3'd4
  } lock_state_e;

  typedef struct packed {
    logic tester_enable;
    logic tester_clear;
    logic unlocked;
    logic program_mode;
    logic locked_out;
  } lock_outs_t;

  function automatic int timer_width(input int lockout_cycles, input int unlock_cycles);
    int longest;
    longest = (lockout_cycles > unlock_cycles) ? lockout_cycles : unlock_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

  function automatic int fail_width(input int max_fails);
    return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// lock_controller_if: handshake between the lock controller and the pin-code
// tester.
//   master - controller side: consumes attempt results, drives code/enable/clear
//   slave  - tester side: produces attempt results, consumes code/enable/clear
interface lock_controller_if #(
  parameter int CODE_LENGTH = 16
) ();
  logic                   attempt_done;   // one-cycle pulse: entry compared
  logic                   attempt_match;  // valid with attempt_done
  logic [CODE_LENGTH-1:0] entry_digits;   // valid with attempt_done
  logic [CODE_LENGTH-1:0] pin_code;       // stored code
  logic                   tester_enable;  // tester may accept digits
  logic                   tester_clear;   // one-cycle pulse: discard entry

  modport master (
    input  attempt_done, attempt_match, entry_digits,
    output pin_code, tester_enable, tester_clear
  );

  modport slave (
    output attempt_done, attempt_match, entry_digits,
    input  pin_code, tester_enable, tester_clear
  );
endinterface

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the unlock window and lockout.
//   clock, reset   - system clock, asynchronous active-high reset
//   i_load         - load i_load_value this edge (wins over i_enable)
//   i_load_value   - value to load
//   i_enable       - count down this edge; holds at 0, never wraps
//   o_expire       - high in the cycle whose closing edge takes the count 1->0,
//                    so the owner can leave its state on that same edge
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_enable & ~i_load & (r_count == WIDTH'(1));

endmodule

// File: rtl/lock_controller.sv
// lock_controller: top-level sequencer for the digital lock's pin-code tester.
// Owns the stored code, counts consecutive failures, enforces lockout, times
// the unlocked window and allows reprogramming while unlocked.
//   clock, reset     - system clock, asynchronous active-high reset
//   tst              - tester handshake (lock_controller_if.master)
//   i_program_req    - pulse: request a code change (honoured when UNLOCKED)
//   i_relock         - pulse: lock immediately
//   o_unlocked       - lock open (UNLOCKED or programming)
//   o_program_mode   - next entry becomes the new code
//   o_locked_out     - lockout active; entries ignored
//   o_fail_count     - consecutive failures, saturating at MAX_FAILS
// Every output is re-registered from the internal state, so an input sampled
// at edge N appears on the outputs after edge N+1.
// Optional: define LOCK_PROGRAM_CONFIRM_EN to require the new code to be
// entered twice (staged in a shadow register) before it is committed.
module lock_controller
  import lock_pkg::*;
#(
  parameter int                   DIGITS         = 4,
  parameter int                   CODE_LENGTH    = 4 * DIGITS,
  parameter int                   MAX_FAILS      = 3,
  parameter int                   LOCKOUT_CYCLES = 50_000_000,
  parameter int                   UNLOCK_CYCLES  = 250_000_000,
  parameter logic [CODE_LENGTH-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                              clock,
  input  logic                              reset,
  lock_controller_if.master                 tst,
  input  logic                              i_program_req,
  input  logic                              i_relock,
  output logic                              o_unlocked,
  output logic                              o_program_mode,
  output logic                              o_locked_out,
  output logic [fail_width(MAX_FAILS)-1:0]  o_fail_count
);

  localparam int FAIL_W  = fail_width(MAX_FAILS);
  localparam int TIMER_W = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES);

  lock_state_e            r_state, w_next_state;
  logic [FAIL_W-1:0]      r_fail_count, w_fail_next;
  logic [CODE_LENGTH-1:0] r_pin_code, w_pin_next;
  logic                   r_clear, w_clear_event, w_attempt_taken;
  logic                   w_timer_load, w_timer_enable, w_expire;
  logic [TIMER_W-1:0]     w_timer_value;
  lock_outs_t             w_outs, r_outs;
  logic [CODE_LENGTH-1:0] r_out_pin;
  logic [FAIL_W-1:0]      r_out_fail;
`ifdef LOCK_PROGRAM_CONFIRM_EN
  logic [CODE_LENGTH-1:0] r_shadow, w_shadow_next;
`endif

  // The timer only runs in the two timed states; PROGRAM freezes it.
  assign w_timer_enable = (r_state == UNLOCKED) || (r_state == LOCKOUT);

  lock_timer #(.WIDTH(TIMER_W)) u_timer (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_timer_load),
    .i_load_value (w_timer_value),
    .i_enable     (w_timer_enable),
    .o_expire     (w_expire)
  );

  // State register, together with the data registers whose next values the
  // next-state logic computes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= LOCKED;
      r_fail_count <= '0;
      r_pin_code   <= DEFAULT_CODE;
      r_clear      <= 1'b0;
`ifdef LOCK_PROGRAM_CONFIRM_EN
      r_shadow     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      r_state      <= w_next_state;
      r_fail_count <= w_fail_next;
      r_pin_code   <= w_pin_next;
      // Gating with ~r_clear guarantees the clear pulse never lasts two cycles.
      r_clear      <= w_clear_event & ~r_clear;
`ifdef LOCK_PROGRAM_CONFIRM_EN
      r_shadow     <= w_shadow_next;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next_state    = r_state;
    w_fail_next     = r_fail_count;
    w_pin_next      = r_pin_code;
    w_timer_load    = 1'b0;
    w_timer_value   = '0;
    w_attempt_taken = 1'b0;
`ifdef LOCK_PROGRAM_CONFIRM_EN
    w_shadow_next   = r_shadow;
`endif
    case (r_state)
      LOCKED: begin
        if (tst.attempt_done) begin
          w_attempt_taken = 1'b1;
          if (tst.attempt_match) begin
            w_next_state  = UNLOCKED;
            w_fail_next   = '0;
            w_timer_load  = 1'b1;
            w_timer_value = TIMER_W'(UNLOCK_CYCLES);
          end else if (int'(r_fail_count) + 1 >= MAX_FAILS) begin
            w_next_state  = LOCKOUT;
            w_fail_next   = FAIL_W'(MAX_FAILS);
            w_timer_load  = 1'b1;
            w_timer_value = TIMER_W'(LOCKOUT_CYCLES);
          end else begin
            w_fail_next   = r_fail_count + 1'b1;
          end
        end
      end
      UNLOCKED: begin
        // Expiry and relock both lock; relock beats a same-cycle program_req.
        if (w_expire || i_relock) begin
          w_next_state = LOCKED;
        end else if (i_program_req) begin
          w_next_state = PROGRAM;
        end
      end
      PROGRAM: begin
        // An entry beats a same-cycle relock; the tester's match is ignored.
        if (tst.attempt_done) begin
          w_attempt_taken = 1'b1;
`ifdef LOCK_PROGRAM_CONFIRM_EN
          w_shadow_next   = tst.entry_digits;
          w_next_state    = PROGRAM_CONFIRM;
`else
          w_pin_next      = tst.entry_digits;
          w_next_state    = LOCKED;
`endif
        end else if (i_relock) begin
          w_next_state = LOCKED;
        end
      end
`ifdef LOCK_PROGRAM_CONFIRM_EN
      PROGRAM_CONFIRM: begin
        if (tst.attempt_done) begin
          w_attempt_taken = 1'b1;
          w_next_state    = LOCKED;
          if (tst.entry_digits == r_shadow) begin
            w_pin_next = r_shadow;
          end
        end else if (i_relock) begin
          w_next_state = LOCKED;
        end
      end
`endif
      LOCKOUT: begin
        if (w_expire) begin
          w_next_state = LOCKED;
          w_fail_next  = '0;
        end
      end
      default: begin
        w_next_state = LOCKED;
        w_fail_next  = '0;
      end
    endcase

    // A commit-and-lock is one event, so it yields a single clear pulse.
    w_clear_event = w_attempt_taken ||
                    ((w_next_state == LOCKED) && (r_state != LOCKED));
  end

  // Output decode from the current state.
  always_comb begin
    w_outs              = '0;
    w_outs.tester_clear = r_clear;
    case (r_state)
      LOCKED:          w_outs.tester_enable = 1'b1;
      UNLOCKED:        w_outs.unlocked      = 1'b1;
      PROGRAM,
      PROGRAM_CONFIRM: begin
        w_outs.tester_enable = 1'b1;
        w_outs.unlocked      = 1'b1;
        w_outs.program_mode  = 1'b1;
      end
      LOCKOUT:         w_outs.locked_out    = 1'b1;
      default:         w_outs.tester_enable = 1'b0;
    endcase
  end

  // Output registers; reset values match the LOCKED state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outs               <= '0;
      r_outs.tester_enable <= 1'b1;
      r_out_pin            <= DEFAULT_CODE;
      r_out_fail           <= '0;
    end else begin
      r_outs               <= w_outs;
      r_out_pin            <= r_pin_code;
      r_out_fail           <= r_fail_count;
    end
  end

  assign tst.pin_code      = r_out_pin;
  assign tst.tester_enable = r_outs.tester_enable;
  assign tst.tester_clear  = r_outs.tester_clear;
  assign o_unlocked        = r_outs.unlocked;
  assign o_program_mode    = r_outs.program_mode;
  assign o_locked_out      = r_outs.locked_out;
  assign o_fail_count      = r_out_fail;

endmodule
